// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter sharing one word-wide memory port
module mem_arbiter #(
  parameter int AW = 30
) (
  input  logic          ph1,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iadr,
  output logic [31:0]   irdata,
  output logic          iack,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] dadr,
  input  logic [31:0]   dwdata,
  input  logic [3:0]    dbyteen,
  output logic [31:0]   drdata,
  output logic          dack,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] madr,
  output logic [31:0]   mwdata,
  output logic [3:0]    mbyteen,
  input  logic [31:0]   mrdata,
  input  logic          mack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic            mreq_q, mreq_d;
  logic            mwe_q, mwe_d;
  logic [AW-1:0]   madr_q, madr_d;
  logic [31:0]     mwdata_q, mwdata_d;
  logic [3:0]      mbyteen_q, mbyteen_d;
  logic [31:0]     irdata_q, irdata_d;
  logic [31:0]     drdata_q, drdata_d;
  logic            iack_q, iack_d;
  logic            dack_q, dack_d;
  logic            grant;

  // Next state, arbitration and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    mreq_d    = mreq_q;
    mwe_d     = mwe_q;
    madr_d    = madr_q;
    mwdata_d  = mwdata_q;
    mbyteen_d = mbyteen_q;
    irdata_d  = irdata_q;
    drdata_d  = drdata_q;
    iack_d    = 1'b0;
    dack_d    = 1'b0;
    grant     = PORT_I;
    case (state_q)
      S_IDLE: begin
        if (ireq || dreq) begin
          // On a tie the port that was not served last wins, so neither starves.
          grant   = (ireq && dreq) ? ~last_q : dreq;
          owner_d = grant;
          last_d  = grant;
          mreq_d  = 1'b1;
          state_d = S_BUSY;
          if (grant == PORT_D) begin
            mwe_d     = dwe;
            madr_d    = dadr;
            mwdata_d  = dwdata;
            mbyteen_d = dbyteen;
          end else begin
            mwe_d     = 1'b0;
            madr_d    = iadr;
            mwdata_d  = 32'h0;
            mbyteen_d = 4'hF;
          end
        end
      end
      S_BUSY: begin
        // Request lines stay frozen until memory completes.
        if (mack) begin
          mreq_d  = 1'b0;
          state_d = S_RESP;
          if (!mwe_q) begin
            if (owner_q == PORT_D) drdata_d = mrdata;
            else                   irdata_d = mrdata;
          end
          iack_d = (owner_q == PORT_I);
          dack_d = (owner_q == PORT_D);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= PORT_I;
      last_q    <= PORT_I;
      mreq_q    <= 1'b0;
      mwe_q     <= 1'b0;
      madr_q    <= '0;
      mwdata_q  <= 32'h0;
      mbyteen_q <= 4'h0;
      irdata_q  <= 32'h0;
      drdata_q  <= 32'h0;
      iack_q    <= 1'b0;
      dack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      mreq_q    <= mreq_d;
      mwe_q     <= mwe_d;
      madr_q    <= madr_d;
      mwdata_q  <= mwdata_d;
      mbyteen_q <= mbyteen_d;
      irdata_q  <= irdata_d;
      drdata_q  <= drdata_d;
      iack_q    <= iack_d;
      dack_q    <= dack_d;
    end
  end

  assign mreq    = mreq_q;
  assign mwe     = mwe_q;
  assign madr    = madr_q;
  assign mwdata  = mwdata_q;
  assign mbyteen = mbyteen_q;
  assign irdata  = irdata_q;
  assign drdata  = drdata_q;
  assign iack    = iack_q;
  assign dack    = dack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 30;

  logic          ph1 = 1'b0;
  logic          reset;
  logic          ireq;
  logic [AW-1:0] iadr;
  logic [31:0]   irdata;
  logic          iack;
  logic          dreq;
  logic          dwe;
  logic [AW-1:0] dadr;
  logic [31:0]   dwdata;
  logic [3:0]    dbyteen;
  logic [31:0]   drdata;
  logic          dack;
  logic          mreq;
  logic          mwe;
  logic [AW-1:0] madr;
  logic [31:0]   mwdata;
  logic [3:0]    mbyteen;
  logic [31:0]   mrdata;
  logic          mack;

  always #5 ph1 = ~ph1;

  mem_arbiter #(.AW(AW)) dut (
    .ph1(ph1), .reset(reset),
    .ireq(ireq), .iadr(iadr), .irdata(irdata), .iack(iack),
    .dreq(dreq), .dwe(dwe), .dadr(dadr), .dwdata(dwdata), .dbyteen(dbyteen),
    .drdata(drdata), .dack(dack),
    .mreq(mreq), .mwe(mwe), .madr(madr), .mwdata(mwdata), .mbyteen(mbyteen),
    .mrdata(mrdata), .mack(mack)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // memory contents seen by the DUT (phys) and by the requester-side model (refm)
  logic [31:0]   phys [64];
  logic [31:0]   refm [64];
  // requester model: one outstanding transaction per port (0 = I, 1 = D)
  bit            active [2];
  int            cool [2];
  int            age [2];
  logic [5:0]    padr [2];
  logic          pwe;
  logic [31:0]   pwd;
  logic [3:0]    pbe;
  logic [31:0]   exp_ird, exp_drd;
  int            n_ack [2];
  int            ack_log [$];
  bit            auto_en;
  int            start_prob;
  // memory responder
  bit            mem_en;
  int            fixed_wait;
  int            mcnt, cur_wait;
  logic [AW-1:0] s_adr;
  logic [31:0]   s_wd;
  logic [4:0]    s_ctl;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic start_i(input logic [5:0] a);
    active[0] = 1'b1; age[0] = 0; padr[0] = a;
    ireq = 1'b1; iadr = AW'(a);
  endtask

  task automatic start_d(input logic we, input logic [5:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
    active[1] = 1'b1; age[1] = 0; padr[1] = a; pwe = we; pwd = wd; pbe = be;
    dreq = 1'b1; dwe = we; dadr = AW'(a); dwdata = wd; dbyteen = be;
  endtask

  task automatic cycle();
    @(posedge ph1);
    #1;
    // memory side: answers after cur_wait extra request cycles
    mrdata = $urandom();
    if (mack) begin
      mack = 1'b0;
      mcnt = 0;
    end else if (!mreq) begin
      mcnt = 0;
    end else if (mem_en) begin
      mcnt++;
      if (mcnt == 1) begin
        cur_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 7));
        s_adr = madr; s_wd = mwdata; s_ctl = {mwe, mbyteen};
      end else begin
        check("madr_stable", 64'(madr), 64'(s_adr));
        check("mwdata_stable", 64'(mwdata), 64'(s_wd));
        check("mwe_mbyteen_stable", 64'({mwe, mbyteen}), 64'(s_ctl));
      end
      if (mcnt == cur_wait + 1) begin
        mack = 1'b1;
        if (mwe) phys[madr[5:0]] = merge(phys[madr[5:0]], mwdata, mbyteen);
        else     mrdata = phys[madr[5:0]];
      end
    end
    // requester side: pair every ack with its own outstanding request
    if (iack || dack) check("one_ack_at_a_time", 64'(iack & dack), 64'd0);
    if (iack) begin
      check("iack_paired", 64'(active[0]), 64'd1);
      if (active[0]) begin
        n_ack[0]++; ack_log.push_back(0);
        exp_ird = refm[padr[0]];
        check("irdata", 64'(irdata), 64'(exp_ird));
        active[0] = 1'b0; cool[0] = 2; ireq = 1'b0; iadr = AW'($urandom());
      end
    end else if (active[0]) begin
      age[0]++;
      if (age[0] > 100) begin
        check("iack_timeout", 64'(age[0]), 64'd100);
        active[0] = 1'b0; ireq = 1'b0;
      end
    end
    if (dack) begin
      check("dack_paired", 64'(active[1]), 64'd1);
      if (active[1]) begin
        n_ack[1]++; ack_log.push_back(1);
        if (pwe) begin
          refm[padr[1]] = merge(refm[padr[1]], pwd, pbe);
          check("drdata_hold_on_write", 64'(drdata), 64'(exp_drd));
        end else begin
          exp_drd = refm[padr[1]];
          check("drdata", 64'(drdata), 64'(exp_drd));
        end
        active[1] = 1'b0; cool[1] = 2; dreq = 1'b0;
        dadr = AW'($urandom()); dwdata = $urandom(); dbyteen = 4'($urandom()); dwe = 1'($urandom());
      end
    end else if (active[1]) begin
      age[1]++;
      if (age[1] > 100) begin
        check("dack_timeout", 64'(age[1]), 64'd100);
        active[1] = 1'b0; dreq = 1'b0;
      end
    end
    // new requests only once the port has stayed low through one IDLE cycle
    for (int p = 0; p < 2; p++) begin
      if (cool[p] > 0) cool[p]--;
      else if (auto_en && !active[p] && (int'($urandom_range(0, 3)) < start_prob)) begin
        if (p == 0) start_i(6'($urandom_range(0, 15)));
        else start_d(1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), $urandom(),
                     4'($urandom_range(0, 15)));
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((active[0] || active[1]) && n < bound) begin
      cycle();
      n++;
    end
    check("drain_within_bound", 64'(active[0] | active[1]), 64'd0);
  endtask

  task automatic do_reset();
    auto_en = 1'b0;
    reset = 1'b1; ireq = 1'b0; dreq = 1'b0; mack = 1'b0;
    cycle();
    cycle();
    for (int p = 0; p < 2; p++) begin active[p] = 1'b0; cool[p] = 0; age[p] = 0; end
    exp_ird = 32'h0; exp_drd = 32'h0; mcnt = 0;
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b1; ireq = 1'b0; iadr = '0; dreq = 1'b0; dwe = 1'b0; dadr = '0;
    dwdata = 32'h0; dbyteen = 4'h0; mrdata = 32'h0; mack = 1'b0;
    auto_en = 1'b0; start_prob = 0; mem_en = 1'b1; fixed_wait = 0; mcnt = 0; cur_wait = 0;
    pwe = 1'b0; pwd = 32'h0; pbe = 4'h0;
    for (int p = 0; p < 2; p++) begin active[p] = 1'b0; cool[p] = 0; age[p] = 0; n_ack[p] = 0; padr[p] = 6'd0; end
    for (int a = 0; a < 64; a++) begin phys[a] = $urandom(); refm[a] = phys[a]; end
    phys[16] = 32'h8C020004; refm[16] = 32'h8C020004;
    phys[32] = 32'h11223344; refm[32] = 32'h11223344;

    // reset values
    do_reset();
    check("rst_mreq", 64'(mreq), 64'd0);
    check("rst_mwe", 64'(mwe), 64'd0);
    check("rst_madr", 64'(madr), 64'd0);
    check("rst_mwdata", 64'(mwdata), 64'd0);
    check("rst_mbyteen", 64'(mbyteen), 64'd0);
    check("rst_acks", 64'({iack, dack}), 64'd0);
    check("rst_irdata", 64'(irdata), 64'd0);
    check("rst_drdata", 64'(drdata), 64'd0);

    // zero-wait instruction fetch
    fixed_wait = 0;
    start_i(6'd16);
    cycle();
    check("t1_mreq_c1", 64'(mreq), 64'd1);
    check("t1_mwe_c1", 64'(mwe), 64'd0);
    check("t1_mbyteen_c1", 64'(mbyteen), 64'hF);
    check("t1_madr_c1", 64'(madr), 64'h10);
    check("t1_iack_c1", 64'(iack), 64'd0);
    cycle();
    check("t1_iack_c2", 64'(iack), 64'd1);
    check("t1_irdata_c2", 64'(irdata), 64'h8C020004);
    check("t1_mreq_c2", 64'(mreq), 64'd0);
    cycle();
    check("t1_iack_c3", 64'(iack), 64'd0);
    cycle();

    // byte-enabled write against a memory with three wait cycles
    fixed_wait = 3;
    base = n_ack[1];
    start_d(1'b1, 6'd32, 32'hDEADBEEF, 4'b0101);
    for (int c = 1; c <= 4; c++) begin
      cycle();
      check("t2_mreq_busy", 64'(mreq), 64'd1);
      check("t2_no_early_dack", 64'(dack), 64'd0);
    end
    cycle();
    check("t2_dack_c5", 64'(dack), 64'd1);
    check("t2_drdata_unchanged", 64'(drdata), 64'd0);
    for (int c = 0; c < 3; c++) cycle();
    check("t2_single_dack", 64'(n_ack[1] - base), 64'd1);
    check("t2_merged_word", 64'(phys[32]), 64'h11AD33EF);
    start_d(1'b0, 6'd32, 32'h0, 4'hF);
    wait_idle(50);
    check("t2_readback", 64'(drdata), 64'h11AD33EF);

    // simultaneous requests right after reset: D first, then strict alternation
    do_reset();
    fixed_wait = 0;
    ack_log.delete();
    auto_en = 1'b1; start_prob = 4;
    for (int c = 0; c < 200 && ack_log.size() < 6; c++) cycle();
    auto_en = 1'b0;
    wait_idle(50);
    check("t3_six_grants", 64'(ack_log.size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < ack_log.size(); i++)
      check("t3_grant_order", 64'(ack_log[i]), 64'((i % 2 == 0) ? 1 : 0));

    // stray mack in IDLE and in RESP
    for (int c = 0; c < 3; c++) cycle();
    mem_en = 1'b0;
    mack = 1'b1;
    cycle();
    check("t4_idle_mack_mreq", 64'(mreq), 64'd0);
    check("t4_idle_mack_acks", 64'({iack, dack}), 64'd0);
    cycle();
    check("t4_idle_mack_acks2", 64'({iack, dack, mreq}), 64'd0);
    mem_en = 1'b1;
    start_i(6'd3);
    cycle();
    cycle();
    check("t4_resp_iack", 64'(iack), 64'd1);
    mack = 1'b1;
    mrdata = 32'hBAD0BAD0;
    cycle();
    check("t4_resp_mack_acks", 64'({iack, dack, mreq}), 64'd0);
    check("t4_resp_mack_irdata", 64'(irdata), 64'(exp_ird));
    cycle();
    check("t4_resp_mack_acks2", 64'({iack, dack, mreq}), 64'd0);

    // reset while BUSY drops the transaction
    fixed_wait = 5;
    start_d(1'b0, 6'd7, 32'h0, 4'hF);
    cycle();
    cycle();
    check("t5_busy_mreq", 64'(mreq), 64'd1);
    reset = 1'b1;
    cycle();
    check("t5_rst_mreq", 64'(mreq), 64'd0);
    check("t5_rst_mfields", 64'({mwe, mbyteen, mwdata}), 64'd0);
    check("t5_rst_madr", 64'(madr), 64'd0);
    check("t5_rst_acks", 64'({iack, dack}), 64'd0);
    check("t5_rst_rdata", {irdata, drdata}, 64'd0);
    active[1] = 1'b0; dreq = 1'b0; exp_ird = 32'h0; exp_drd = 32'h0;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("t5_no_ack_after_abort", 64'({iack, dack}), 64'd0);
    end
    fixed_wait = 2;
    base = n_ack[0];
    start_i(6'd5);
    wait_idle(50);
    check("t5_later_req_done", 64'(n_ack[0] - base), 64'd1);

    // long random mix of reads, byte-enabled writes and latencies 0..7
    fixed_wait = -1;
    auto_en = 1'b1; start_prob = 1;
    for (int c = 0; c < 3000; c++) cycle();
    auto_en = 1'b0;
    wait_idle(200);
    for (int a = 0; a < 16; a++) check("final_memory", 64'(phys[a]), 64'(refm[a]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
